// File: rtl/qmem_traffic_gen.sv
// Pseudo-random qmem bus master: issues a run of LFSR-driven read/write transfers
// and reports per-type counts, error count and an XOR checksum of the read data.
module qmem_traffic_gen #(
  parameter int             QAW      = 32,
  parameter int             QDW      = 32,
  parameter int             QSW      = QDW / 8,
  parameter logic [QAW-1:0] ADR_BASE = '0,
  parameter logic [QAW-1:0] ADR_MSK  = 'h0000_0ffc,
  parameter logic [31:0]    SEED     = 32'h1234_5678,
  parameter int             GAP_MAX  = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [15:0]    count,
  output logic           busy,
  output logic           done,
  output logic           cs,
  output logic           we,
  output logic [QAW-1:0] adr,
  output logic [QSW-1:0] sel,
  output logic [QDW-1:0] dat_w,
  input  logic [QDW-1:0] dat_r,
  input  logic           ack,
  input  logic           err,
  output logic [15:0]    wr_cnt,
  output logic [15:0]    rd_cnt,
  output logic [15:0]    err_cnt,
  output logic [QDW-1:0] rd_xor,
  output logic [2:0]     dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_REQ   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [31:0] TAPS     = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [2:0]     state_q;
  logic [31:0]    lfsr;
  logic [15:0]    count_q;
  logic [15:0]    xfer_cnt;
  logic [3:0]     gap_cnt;
  logic           rd_ack_q;
  logic [QSW-1:0] sel_q;

  logic [31:0]    lfsr_nxt;
  logic [3:0]     gap_nxt;
  logic [1:0]     low_nxt;
  logic [QAW-1:0] adr_nxt;
  logic [QSW-1:0] sel_nxt;
  logic [QDW-1:0] dat_nxt;
  logic [QDW-1:0] rd_mask;
  logic           xfer_end;
  logic           last_xfer;
  logic           issue;

  assign dbg_state = state_q;

  // All request fields and the following gap are decoded from the current LFSR word.
  always_comb begin
    lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);
    gap_nxt  = 4'(32'(lfsr[7:4]) % (GAP_MAX + 1));
    low_nxt  = 2'b00;
    sel_nxt  = QSW'(4'b1111);
    case (lfsr[3:2])
      2'd0: begin
        low_nxt = lfsr[9:8];
        sel_nxt = QSW'(4'b0001 << lfsr[9:8]);
      end
      2'd1: begin
        low_nxt = {lfsr[9], 1'b0};
        sel_nxt = lfsr[9] ? QSW'(4'b1100) : QSW'(4'b0011);
      end
      default: begin
        low_nxt = 2'b00;
        sel_nxt = QSW'(4'b1111);
      end
    endcase
    adr_nxt = ADR_BASE | (QAW'({lfsr[31:8], 2'b00}) & ADR_MSK) | QAW'(low_nxt);
    dat_nxt = QDW'({lfsr[15:0], lfsr[31:16]});
  end

  always_comb begin
    rd_mask = '0;
    for (int i = 0; i < QSW; i++) begin
      rd_mask[8*i +: 8] = {8{sel_q[i]}};
    end
  end

  assign xfer_end  = (state_q == S_REQ) && (ack || err);
  assign last_xfer = (xfer_cnt == count_q - 16'd1);
  // A zero gap keeps cs high and presents the next request straight after ack.
  assign issue = ((state_q == S_GAP) && (gap_cnt == 4'd0)) ||
                 (xfer_end && !last_xfer && (gap_nxt == 4'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs    <= 1'b0;
      we    <= 1'b0;
      adr   <= '0;
      sel   <= '0;
      dat_w <= '0;
      lfsr  <= SEED_EFF;
    end else if (issue) begin
      cs    <= 1'b1;
      we    <= lfsr[0];
      adr   <= adr_nxt;
      sel   <= sel_nxt;
      dat_w <= dat_nxt;
      lfsr  <= lfsr_nxt;
    end else if (xfer_end) begin
      cs <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      xfer_cnt <= '0;
      gap_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      err_cnt  <= '0;
      rd_xor   <= '0;
      rd_ack_q <= 1'b0;
      sel_q    <= '0;
    end else begin
      done     <= 1'b0;
      rd_ack_q <= 1'b0;
      // Read data arrives one cycle after its ack; sel_q holds that transfer's lanes.
      if (rd_ack_q) begin
        rd_xor <= rd_xor ^ (dat_r & rd_mask);
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            count_q  <= count;
            xfer_cnt <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            err_cnt  <= '0;
            rd_xor   <= '0;
            busy     <= 1'b1;
            state_q  <= (count == 16'd0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          gap_cnt <= gap_nxt;
          state_q <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end else begin
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (xfer_end) begin
            sel_q    <= sel;
            xfer_cnt <= xfer_cnt + 16'd1;
            if (err) begin
              if (err_cnt != 16'hffff) begin
                err_cnt <= err_cnt + 16'd1;
              end
            end else if (we) begin
              wr_cnt <= wr_cnt + 16'd1;
            end else begin
              rd_cnt   <= rd_cnt + 16'd1;
              rd_ack_q <= 1'b1;
            end
            if (last_xfer) begin
              state_q <= S_DRAIN;
            end else if (gap_nxt != 4'd0) begin
              gap_cnt <= gap_nxt - 4'd1;
              state_q <= S_GAP;
            end
          end
        end
        S_DRAIN: begin
          state_q <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qmem_traffic_gen.sv
// Bench for qmem_traffic_gen: a qmem slave with wait states, error injection and a
// word memory, checked against a transfer-list model derived from the LFSR rules.
module tb_qmem_traffic_gen;

  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam logic [31:0] MSK     = 32'h0000_0ffc;
  localparam logic [31:0] SEED    = 32'h1234_5678;
  localparam int          GAP_MAX = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] count = '0;
  logic        busy, done, cs, we;
  logic [31:0] adr, dat_w, rd_xor;
  logic [3:0]  sel;
  logic [31:0] dat_r = '0;
  logic        ack = 1'b0;
  logic        err = 1'b0;
  logic [15:0] wr_cnt, rd_cnt, err_cnt;
  logic [2:0]  dbg_state;

  qmem_traffic_gen #(
    .ADR_BASE(BASE), .ADR_MSK(MSK), .SEED(SEED), .GAP_MAX(GAP_MAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .busy(busy), .done(done),
    .cs(cs), .we(we), .adr(adr), .sel(sel), .dat_w(dat_w), .dat_r(dat_r),
    .ack(ack), .err(err), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt),
    .rd_xor(rd_xor), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;

  logic [31:0] exp_adr_q[$];
  logic [3:0]  exp_sel_q[$];
  logic [31:0] exp_dat_q[$];
  logic [0:0]  exp_we_q[$];
  logic [3:0]  exp_gap_q[$];

  logic [31:0] m_lfsr = SEED;
  logic [31:0] exp_xor;
  logic [15:0] exp_wr, exp_rd, exp_err;
  int          done_pulses;

  // slave configuration and memory
  int          cfg_wait = 0;
  int          cfg_err_idx = -1;
  logic        cfg_wr_en = 1'b1;
  logic        cfg_hash = 1'b1;
  logic [31:0] cfg_fill = 32'h0;
  logic [31:0] mem [logic [29:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [29:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return cfg_hash ? (({2'b00, wa} * 32'h9E37_79B1) ^ cfg_fill) : cfg_fill;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic sel_legal(input logic [1:0] a, input logic [3:0] s);
    case (s)
      4'h1:    return a == 2'd0;
      4'h2:    return a == 2'd1;
      4'h4:    return a == 2'd2;
      4'h8:    return a == 2'd3;
      4'h3:    return a == 2'd0;
      4'hc:    return a == 2'd2;
      4'hf:    return a == 2'd0;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: one transfer from an LFSR word, using plain arithmetic on the field rules.
  task automatic model_xfer(input logic [31:0] l, output logic [31:0] a, output logic [3:0] s,
                            output logic [31:0] d, output logic w, output logic [3:0] g,
                            output logic [31:0] l_next);
    int unsigned size, lo;
    size = (l >> 2) & 3;
    lo   = (l >> 8) & 3;
    a    = BASE | (((l >> 8) << 2) & MSK);
    if (size == 0) begin
      a = a | lo;
      s = 4'(1 << lo);
    end else if (size == 1) begin
      a = a | (lo & 2);
      s = (lo >= 2) ? 4'hc : 4'h3;
    end else begin
      s = 4'hf;
    end
    d = (l << 16) | (l >> 16);
    w = l[0];
    g = 4'(((l >> 4) & 15) % (GAP_MAX + 1));
    l_next = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endtask

  // ---------------- slave / monitor ----------------
  logic        in_xfer = 1'b0;
  logic        pend_rd = 1'b0;
  logic [31:0] pend_dat = '0;
  int          wait_left = 0;
  int          cs_cycles = 0;
  int          low_cycles = 0;
  int          xfer_idx = 0;
  logic [31:0] cap_adr, cap_dat, e_adr, e_dat, wword;
  logic [3:0]  cap_sel, e_sel, e_gap;
  logic        cap_we, e_we;

  always @(negedge clk) begin
    dat_r = pend_rd ? pend_dat : $urandom;
    pend_rd = 1'b0;
    ack = 1'b0;
    err = 1'b0;
    if (rst) begin
      in_xfer = 1'b0;
      low_cycles = 0;
    end else if (cs) begin
      if (!in_xfer) begin
        in_xfer = 1'b1;
        wait_left = cfg_wait;
        cs_cycles = 0;
        cap_adr = adr; cap_sel = sel; cap_dat = dat_w; cap_we = we;
        e_sel = sel;
        if (exp_adr_q.size() == 0) begin
          chk("unexpected_cs", 1, 0);
        end else begin
          e_adr = exp_adr_q.pop_front();
          e_sel = exp_sel_q.pop_front();
          e_dat = exp_dat_q.pop_front();
          e_we  = exp_we_q.pop_front();
          e_gap = exp_gap_q.pop_front();
          chk("adr", adr, e_adr);
          chk("sel", sel, e_sel);
          chk("we", we, e_we);
          chk("dat_w", dat_w, e_dat);
          if (xfer_idx > 0) chk("gap", low_cycles, e_gap);
        end
        chk("sel_legal", sel_legal(adr[1:0], sel), 1);
      end else begin
        chk("hold_adr_dat", {adr, dat_w}, {cap_adr, cap_dat});
        chk("hold_sel_we", {sel, we}, {cap_sel, cap_we});
      end
      cs_cycles++;
      if (wait_left == 0) begin
        chk("cs_cycles", cs_cycles, cfg_wait + 1);
        if (xfer_idx == cfg_err_idx) begin
          err = 1'b1;
          ack = 1'($urandom_range(0, 1));
        end else begin
          ack = 1'b1;
          if (cap_we) begin
            if (cfg_wr_en) begin
              wword = mem_rd(cap_adr[31:2]);
              for (int b = 0; b < 4; b++)
                if (cap_sel[b]) wword[8*b +: 8] = cap_dat[8*b +: 8];
              mem[cap_adr[31:2]] = wword;
            end
          end else begin
            pend_rd = 1'b1;
            pend_dat = mem_rd(cap_adr[31:2]);
            exp_xor = exp_xor ^ (pend_dat & byte_mask(e_sel));
          end
        end
        in_xfer = 1'b0;
        xfer_idx++;
        low_cycles = 0;
      end else begin
        wait_left--;
      end
    end else begin
      low_cycles++;
    end
  end

  always @(negedge clk) if (done) done_pulses++;

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [15:0] cnt);
    logic [31:0] a, d, ln;
    logic [3:0]  s, g;
    logic        w;
    exp_adr_q.delete(); exp_sel_q.delete(); exp_dat_q.delete();
    exp_we_q.delete(); exp_gap_q.delete();
    exp_wr = '0; exp_rd = '0; exp_err = '0; exp_xor = '0;
    for (int i = 0; i < int'(cnt); i++) begin
      model_xfer(m_lfsr, a, s, d, w, g, ln);
      exp_adr_q.push_back(a); exp_sel_q.push_back(s); exp_dat_q.push_back(d);
      exp_we_q.push_back(w); exp_gap_q.push_back(g);
      if (i == cfg_err_idx) exp_err++;
      else if (w) exp_wr++;
      else exp_rd++;
      m_lfsr = ln;
    end
    xfer_idx = 0;
    done_pulses = 0;
    @(negedge clk);
    start = 1'b1;
    count = cnt;
    @(negedge clk);
    start = 1'b0;
    count = 16'($urandom);
    chk("busy_after_start", busy, 1);
    if (cnt >= 16'd8) begin
      // A second start while busy must be ignored.
      @(negedge clk);
      start = 1'b1;
      count = 16'd0;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic finish_run(input logic [15:0] cnt);
    int lat;
    lat = 0;
    for (int c = 1; c <= 5000; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c + 1;
        break;
      end
    end
    chk("done_seen", (lat != 0), 1);
    if (cnt == 16'd0) chk("done_latency", lat, 2);
    chk("busy_at_done", busy, 0);
    chk("wr_cnt", wr_cnt, exp_wr);
    chk("rd_cnt", rd_cnt, exp_rd);
    chk("err_cnt", err_cnt, exp_err);
    chk("rd_xor", rd_xor, exp_xor);
    chk("xfers_left", exp_adr_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("done_once", done_pulses, 1);
    chk("idle_cs", cs, 0);
  endtask

  task automatic run(input logic [15:0] cnt, input int wt, input int eidx,
                     input logic wr_en, input logic hash, input logic [31:0] fill);
    cfg_wait = wt;
    cfg_err_idx = eidx;
    cfg_wr_en = wr_en;
    cfg_hash = hash;
    cfg_fill = fill;
    start_run(cnt);
    finish_run(cnt);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int got;
    int rc;
    repeat (2) @(negedge clk);
    chk("rst_cs_we", {cs, we}, 0);
    chk("rst_adr_dat", {adr, dat_w}, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_counts", {wr_cnt, rd_cnt, err_cnt}, 0);
    chk("rst_xor", rd_xor, 0);
    rst = 1'b0;

    // empty run
    run(16'd0, 0, -1, 1'b1, 1'b1, 32'h0);
    // immediate ack
    run(16'd8, 0, -1, 1'b1, 1'b1, 32'h3c3c_0f0f);
    // three wait states
    run(16'($urandom_range(20, 30)), 3, -1, 1'b1, 1'b1, 32'h0);
    // error on third transfer
    run(16'd10, $urandom_range(0, 2), 2, 1'b1, 1'b1, 32'h1111_2222);

    // reset in the middle of a request, then rerun from the seed
    cfg_wait = 3;
    cfg_err_idx = -1;
    start_run(16'd10);
    got = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cs) begin
        got = 1;
        break;
      end
    end
    chk("rst_wait_cs", got, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_cs", cs, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_adr", adr, 0);
    @(negedge clk);
    @(negedge clk);
    exp_adr_q.delete(); exp_sel_q.delete(); exp_dat_q.delete();
    exp_we_q.delete(); exp_gap_q.delete();
    m_lfsr = SEED;
    rst = 1'b0;
    run(16'd12, 1, -1, 1'b1, 1'b1, 32'h0);

    // constant memory, writes dropped by the slave
    mem.delete();
    run(16'd40, 0, -1, 1'b0, 1'b0, 32'hA5A5_A5A5);

    // random runs
    for (int r = 0; r < 4; r++) begin
      rc = $urandom_range(8, 30);
      run(16'(rc), $urandom_range(0, 3),
          ($urandom_range(0, 1) == 1) ? $urandom_range(0, rc - 1) : -1,
          1'b1, 1'b1, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
